// File: rtl/spm_fifo_ctrl.sv
// rtl/spm_fifo_ctrl.sv - FIFO controller over a single-port memory
// One memory access per cycle: write or read, arbitrated with fair priority under contention.
module spm_fifo_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_req,
  output logic          pop_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_din,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              prio_q, prio_d;
  logic [RD_LAT-1:0] rv_q, rv_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DW-1:0]     pop_data_q, pop_data_d;

  logic wr_elig, rd_elig, contended;
  logic wr_grant, rd_grant;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);

  // prio only breaks ties; a lone eligible request always wins.
  always_comb begin
    wr_elig   = push && !full;
    rd_elig   = pop_req && !empty;
    contended = wr_elig && rd_elig;
    wr_grant  = wr_elig && (!rd_elig || !prio_q);
    rd_grant  = rd_elig && (!wr_elig || prio_q);
  end

  always_comb begin
    mem_wen     = 1'b0;
    mem_address = rd_ptr_q;
    mem_din     = '0;
    if (wr_grant) begin
      mem_wen     = reset_n;
      mem_address = wr_ptr_q;
      mem_din     = push_data;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prio_d      = prio_q;
    rv_d        = '0;
    pop_valid_d = rv_q[RD_LAT-1];
    pop_data_d  = pop_data_q;
    if (wr_grant) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(1);
    end
    if (rd_grant) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - (AW+1)'(1);
    end
    if (contended) begin
      prio_d = !prio_q;
    end
    rv_d[0] = rd_grant;
    for (int i = 1; i < RD_LAT; i++) begin
      rv_d[i] = rv_q[i-1];
    end
    if (rv_q[RD_LAT-1]) begin
      pop_data_d = mem_dout;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prio_q      <= 1'b0;
      rv_q        <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prio_q      <= prio_d;
      rv_q        <= rv_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign push_ready = wr_grant;
  assign pop_ready  = rd_grant;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign count      = count_q;

endmodule

// File: doc/spm_fifo_ctrl.md
# spm_fifo_ctrl

FIFO controller that turns the 256 x 16 single-port memory into a first-in/first-out queue. It sits directly upstream of the memory: it drives the memory's `address`/`din`/`wen` and consumes its `dout`. It arbitrates the one memory port between producer pushes and consumer pops, one access per cycle. It tracks occupancy and returns read data after the memory's read latency.

## Interface
- `AW`, 8: memory address width; FIFO depth is 2^AW.
- `DW`, 16: data width.
- `RD_LAT`, 1: cycles from a read-issue edge to valid `mem_dout`; must be ≥1.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `push`  in  1  producer requests a write of `push_data`.
- `push_data`  in  DW  write data.
- `push_ready`  out  1  the write is granted this cycle; a transfer occurs when `push && push_ready`.
- `pop_req`  in  1  consumer requests one word.
- `pop_ready`  out  1  the read is granted this cycle; a read is issued when `pop_req && pop_ready`.
- `pop_valid`  out  1  one-cycle pulse: `pop_data` holds the oldest issued read.
- `pop_data`  out  DW  read data; holds its value between pulses.
- `count`  out  AW+1  committed occupancy, 0..2^AW.
- `empty`, `full`  out  1  `count==0`, `count==2^AW`.
- `mem_address`  out  AW  to memory `address`.
- `mem_din`  out  DW  to memory `din`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_dout`  in  DW  from memory `dout`.

## Operation
- State: `wr_ptr[AW-1:0]`, `rd_ptr[AW-1:0]`, `count[AW:0]`, `prio` (0 = write favoured, 1 = read favoured), read-valid shift register `rv[RD_LAT-1:0]`.
- Eligibility:
  - A write is eligible when `push && !full`.
  - A read is eligible when `pop_req && !empty`.
- Arbitration, combinational, at most one grant per cycle:
  - If only one request is eligible, it is granted.
  - If both are eligible, `prio` picks the winner, and `prio` toggles to favour the loser on the next cycle.
  - `prio` changes only on contended cycles.
- Memory drive, combinational from the grant:
  - Write grant: `mem_wen=1`, `mem_address=wr_ptr`, `mem_din=push_data`.
  - Read grant: `mem_wen=0`, `mem_address=rd_ptr`.
  - Idle: `mem_wen=0`, `mem_address=rd_ptr`, `mem_din=0`.
  - `mem_wen` is forced to 0 while `reset_n=0`.
- On a clock edge with a write grant: `wr_ptr` increments, and `count` increments.
- On a clock edge with a read grant: `rd_ptr` increments, `count` decrements, and a 1 enters `rv[0]`.
- Pointers wrap modulo 2^AW (255 → 0). `count` never wraps; eligibility guarantees this.
- Read return:
  - When `rv[RD_LAT-1]` is 1, `pop_data` captures `mem_dout` and `pop_valid` pulses.
  - Reads may issue back-to-back, giving one pulse per cycle.
  - The consumer cannot stall `pop_valid`.
- `count` reflects committed entries. An entry leaves `count` at its read-issue edge, not at its return.
- Reset (asynchronous, any time):
  - Pointers, `count`, `prio`, `rv`, and `pop_data` clear to 0.
  - `pop_valid=0`, `empty=1`, `full=0`.
  - In-flight reads are discarded and never pulse.
  - Memory contents are not cleared and are not relied upon.

## Timing
- Write: a `push` granted in cycle N is written at edge N. `count` and `empty` update after edge N.
- Read: granted in cycle N, address presented in cycle N. `pop_valid` is high in the cycle after edge N+RD_LAT; with RD_LAT=1 that is cycle N+2.
- Write then read of the same entry: the earliest read grant is cycle N+1, because `empty` deasserts after edge N.
- Empty with simultaneous `push` and `pop_req`: the write wins regardless of `prio`, and `prio` is unchanged.
- Full with simultaneous requests: the read wins regardless of `prio`, and `prio` is unchanged.
- Sustained contention: grants alternate W, R, W, R, starting with a write after reset.
- Reset released mid-stream: the first grant is possible in the first cycle after deassertion.

## Test plan
- Reset, then push 0x0010, 0x0013, 0x0060, 0x0050 on consecutive cycles, then assert `pop_req` for 4 cycles.
  - Required: `count` reaches 4; `mem_address` is 0..3 on writes.
  - Required: `pop_valid` pulses 4 times with the data in push order; `count` returns to 0 and `empty` is 1.
- Push 256 words of value i.
  - Required: `full=1` and `count=256`; a 257th push sees `push_ready=0` and `mem_wen=0`.
  - Then pop all 256. Required: the data is 0..255 in order, and `empty=1`.
- Hold `push` and `pop_req` high together with `count` at 5.
  - Required: grants alternate W, R, W, R for 8 cycles, and `count` stays in 5..6.
  - Required: each read's data matches the expected FIFO order.
- Wrap-around: fill 200, drain 200, then push 100 and pop 100.
  - Required: `wr_ptr` passes through 255 → 0, and the data stays intact and in order.
- Issue a read, then assert `reset_n=0` before its `pop_valid`.
  - Required: there is no `pop_valid` pulse; `count=0`, `empty=1`, and `mem_wen=0` during reset.
- Empty FIFO with `push` and `pop_req` asserted together.
  - Required: the write is granted, `pop_ready=0` that cycle, and the read is granted the next cycle.
